// File: rtl/breakout_pkg.sv
// Shared constants and state encoding for the breakout paddle, ball and collision blocks.
package breakout_pkg;

    localparam int unsigned SCREEN_W_DEF = 320;
    localparam int unsigned HALF_W_DEF   = 40;
    localparam int unsigned STEP_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE_L = 2'd1,
        ST_MOVE_R = 2'd2
    } paddle_state_e;

endpackage

// File: rtl/paddle_ctrl_if.sv
// Button requests in, paddle position/status out; master drives buttons, slave is the paddle.
interface paddle_ctrl_if #(
    parameter int unsigned X_W = 10
) ();
    logic           btn_left;
    logic           btn_right;
    logic           recenter;
    logic [X_W-1:0] x;
    logic [2:0]     step;
    logic           moving;
    logic           at_left;
    logic           at_right;
    logic           tick;

    modport master (
        output btn_left, btn_right, recenter,
        input  x, step, moving, at_left, at_right, tick
    );

    modport slave (
        input  btn_left, btn_right, recenter,
        output x, step, moving, at_left, at_right, tick
    );
endinterface

// File: rtl/paddle_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, first one TICK_DIV cycles after reset.
module paddle_tick_gen #(
    parameter int unsigned TICK_DIV = 833333
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: button-driven movement with per-tick acceleration, wall clamping and recenter.
module paddle_ctrl
    import breakout_pkg::*;
#(
    parameter int unsigned SCREEN_W    = SCREEN_W_DEF,
    parameter int unsigned HALF_W      = HALF_W_DEF,
    parameter int unsigned X_W         = 10,
    parameter int unsigned TICK_DIV    = 833333,
    parameter int unsigned STEP_MIN    = 1,
    parameter int unsigned STEP_MAX    = 4,
    parameter int unsigned ACCEL_TICKS = 8
) (
    input logic         clk,
    input logic         resetn,
    paddle_ctrl_if.slave pif
);
    localparam int unsigned XW1    = X_W + 1;
    localparam int unsigned X_MIN  = HALF_W;
    localparam int unsigned X_MAX  = SCREEN_W - 1 - HALF_W;
    localparam int unsigned X_CTR  = SCREEN_W / 2;
    localparam int unsigned HOLD_W = $clog2(ACCEL_TICKS + 1);

    paddle_state_e     r_state, w_state_n, w_dir;
    logic [X_W-1:0]    r_x, w_x_n;
    logic [STEP_W-1:0] r_step, w_step_n, w_step_mv;
    logic [HOLD_W-1:0] r_hold, w_hold_n, w_hold_inc;
    logic [XW1-1:0]    w_x_ext, w_left_lim, w_sum;
    logic              w_tick, w_entering;

    paddle_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .tick   (w_tick)
    );

    // Conflicting or absent buttons both mean stop.
    always_comb begin
        w_dir = ST_IDLE;
        if (pif.btn_left && !pif.btn_right)
            w_dir = ST_MOVE_L;
        else if (!pif.btn_left && pif.btn_right)
            w_dir = ST_MOVE_R;
    end

    // The tick that enters a direction already counts as its first held tick.
    assign w_entering = (w_dir != r_state);
    assign w_step_mv  = w_entering ? STEP_W'(STEP_MIN) : r_step;
    assign w_hold_inc = w_entering ? HOLD_W'(1) : r_hold + HOLD_W'(1);
    assign w_x_ext    = XW1'(r_x);
    assign w_left_lim = XW1'(X_MIN) + XW1'(w_step_mv);
    assign w_sum      = w_x_ext + XW1'(w_step_mv);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_x     <= X_W'(X_CTR);
            r_step  <= STEP_W'(STEP_MIN);
            r_hold  <= '0;
        end else begin
            r_state <= w_state_n;
            r_x     <= w_x_n;
            r_step  <= w_step_n;
            r_hold  <= w_hold_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_x_n     = r_x;
        w_step_n  = r_step;
        w_hold_n  = r_hold;
        if (pif.recenter) begin
            w_state_n = ST_IDLE;
            w_x_n     = X_W'(X_CTR);
            w_step_n  = STEP_W'(STEP_MIN);
            w_hold_n  = '0;
        end else if (w_tick) begin
            w_state_n = w_dir;
            w_step_n  = w_step_mv;
            w_hold_n  = '0;
            case (w_dir)
                ST_MOVE_L: w_x_n = (w_x_ext < w_left_lim) ? X_W'(X_MIN)
                                                          : X_W'(w_x_ext - XW1'(w_step_mv));
                ST_MOVE_R: w_x_n = (w_sum > XW1'(X_MAX)) ? X_W'(X_MAX) : X_W'(w_sum);
                default:   w_x_n = r_x;
            endcase
            if (w_dir != ST_IDLE) begin
                if (w_hold_inc == HOLD_W'(ACCEL_TICKS))
                    w_step_n = (w_step_mv < STEP_W'(STEP_MAX)) ? w_step_mv + STEP_W'(1) : w_step_mv;
                else
                    w_hold_n = w_hold_inc;
            end
        end
    end

    assign pif.x        = r_x;
    assign pif.step     = r_step;
    assign pif.tick     = w_tick;
    assign pif.moving   = (r_state != ST_IDLE);
    assign pif.at_left  = (r_x == X_W'(X_MIN));
    assign pif.at_right = (r_x == X_W'(X_MAX));

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with TICK_DIV = 4 and default geometry.
module tb_paddle_ctrl;

    logic clk;
    logic resetn;
    int   n_pass;
    int   n_fail;
    int   n_total;
    int   guard;

    paddle_ctrl_if #(.X_W(10)) pif ();

    paddle_ctrl #(.TICK_DIV(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .pif    (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n movement ticks; returns at the falling edge just after the last tick edge.
    task automatic run_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            int g;
            g = 0;
            @(negedge clk);
            while (pif.tick !== 1'b1 && g < 8) begin
                @(negedge clk);
                g++;
            end
            check("tick_arrives", 32'(pif.tick), 32'd1);
        end
        @(negedge clk);
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0; guard = 0;
        resetn = 1'b0;
        pif.btn_left = 1'b0; pif.btn_right = 1'b0; pif.recenter = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_x",      32'(pif.x),      32'd160);
        check("rst_step",   32'(pif.step),   32'd1);
        check("rst_moving", 32'(pif.moving), 32'd0);
        check("rst_tick",   32'(pif.tick),   32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("rel_tick_early", 32'(pif.tick), 32'd0);
        @(negedge clk);
        check("rel_tick_at4", 32'(pif.tick), 32'd1);
        @(negedge clk);

        // Accelerate right: 8 ticks at 1, 8 at 2, then 3
        pif.btn_right = 1'b1;
        run_ticks(8);
        check("r8_x",    32'(pif.x),    32'd168);
        check("r8_step", 32'(pif.step), 32'd2);
        run_ticks(8);
        check("r16_x",    32'(pif.x),    32'd184);
        check("r16_step", 32'(pif.step), 32'd3);
        run_ticks(4);
        check("r20_x",      32'(pif.x),      32'd196);
        check("r20_moving", 32'(pif.moving), 32'd1);
        run_ticks(2);
        check("r22_x", 32'(pif.x), 32'd202);

        // Reverse: step restarts at 1, reaches 4 and saturates
        pif.btn_right = 1'b0; pif.btn_left = 1'b1;
        run_ticks(24);
        check("l24_x",    32'(pif.x),    32'd154);
        check("l24_step", 32'(pif.step), 32'd4);
        run_ticks(28);
        check("l52_x",    32'(pif.x),       32'd42);
        check("l52_step", 32'(pif.step),    32'd4);
        check("l52_atl",  32'(pif.at_left), 32'd0);
        run_ticks(1);
        check("lwall_x",   32'(pif.x),       32'd40);
        check("lwall_atl", 32'(pif.at_left), 32'd1);
        run_ticks(2);
        check("lhold_x",      32'(pif.x),      32'd40);
        check("lhold_moving", 32'(pif.moving), 32'd1);
        check("lhold_step",   32'(pif.step),   32'd4);

        // Both buttons: idle, position held, step back to 1
        pif.btn_right = 1'b1;
        run_ticks(3);
        check("both_x",      32'(pif.x),       32'd40);
        check("both_moving", 32'(pif.moving),  32'd0);
        check("both_step",   32'(pif.step),    32'd1);
        check("both_atl",    32'(pif.at_left), 32'd1);

        // Right from the wall to x = 200, then async reset mid-move
        pif.btn_left = 1'b0;
        run_ticks(52);
        check("r200_x", 32'(pif.x), 32'd200);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("arst_x",      32'(pif.x),      32'd160);
        check("arst_moving", 32'(pif.moving), 32'd0);
        check("arst_step",   32'(pif.step),   32'd1);
        check("arst_tick",   32'(pif.tick),   32'd0);
        @(negedge clk);
        pif.btn_right = 1'b0; pif.btn_left = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("rel2_tick_early", 32'(pif.tick), 32'd0);
        @(negedge clk);
        check("rel2_tick_at4", 32'(pif.tick), 32'd1);
        run_ticks(1);
        check("l2_x", 32'(pif.x), 32'd158);

        // Right to x = 250, then recenter on a tick cycle
        pif.btn_left = 1'b0; pif.btn_right = 1'b1;
        run_ticks(35);
        check("r250_x",      32'(pif.x),      32'd250);
        check("r250_moving", 32'(pif.moving), 32'd1);
        guard = 0;
        while (pif.tick !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        check("rc_on_tick", 32'(pif.tick), 32'd1);
        pif.recenter = 1'b1;
        @(posedge clk);
        #1 pif.recenter = 1'b0;
        @(negedge clk);
        check("rc_x",      32'(pif.x),      32'd160);
        check("rc_moving", 32'(pif.moving), 32'd0);
        check("rc_step",   32'(pif.step),   32'd1);
        check("rc_tick_low", 32'(pif.tick), 32'd0);
        repeat (3) @(negedge clk);
        check("rc_tick_cadence", 32'(pif.tick), 32'd1);

        // Drive into the right wall: 44 ticks from centre overshoots and clamps
        run_ticks(43);
        check("rwall_x",    32'(pif.x),        32'd279);
        check("rwall_atr",  32'(pif.at_right), 32'd1);
        check("rwall_step", 32'(pif.step),     32'd4);

        // Recenter off a tick edge
        pif.recenter = 1'b1;
        @(negedge clk);
        pif.recenter = 1'b0;
        check("rc2_x",   32'(pif.x),        32'd160);
        check("rc2_atr", 32'(pif.at_right), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter SCREEN_W, default 320; screen width in pixels.
REQ-002 Parameter HALF_W, default 40; paddle half-width in pixels.
REQ-003 Parameter X_W, default 10; width of the position bus.
REQ-004 Parameter TICK_DIV, default 833333; clk cycles per movement tick (60 Hz at 50 MHz).
REQ-005 Parameter STEP_MIN, default 1; initial pixels per tick.
REQ-006 Parameter STEP_MAX, default 4; top pixels per tick.
REQ-007 Parameter ACCEL_TICKS, default 8; consecutive same-direction ticks per step increment.
REQ-008 Port clk, input, 1, sole clock; all state is rising-edge.
REQ-009 Port resetn, input, 1; one clock; reset is asynchronous and active-low.
REQ-010 Port btn_left, input, 1, active-high move-left request, already synchronised.
REQ-011 Port btn_right, input, 1, active-high move-right request, already synchronised.
REQ-012 Port recenter, input, 1, synchronous request to snap the paddle to centre.
REQ-013 Port x, output, X_W, registered paddle centre position.
REQ-014 Port step, output, 3, current pixels-per-tick.
REQ-015 Port moving, output, 1, high when state is not IDLE.
REQ-016 Port at_left / at_right, output, 1 each, high when x equals X_MIN / X_MAX.
REQ-017 Port tick, output, 1, one-cycle movement-tick strobe.

Function
REQ-018 The block SHALL use derived constants X_MIN = HALF_W, X_MAX = SCREEN_W-1-HALF_W, X_CTR = SCREEN_W/2.
REQ-019 Tick: a counter SHALL count 0..TICK_DIV-1 and assert tick for exactly one cycle when it wraps to 0.
REQ-020 The FSM SHALL have states IDLE, MOVE_L and MOVE_R; state, x, step and the hold count SHALL change only on tick cycles, except as stated in REQ-025 and REQ-026.
REQ-021 Direction decode on each tick: left only -> MOVE_L; right only -> MOVE_R; both or neither -> IDLE.
REQ-022 Entering a new direction, or entering IDLE, SHALL set step = STEP_MIN and clear the hold count.
REQ-023 Each tick in an unchanged direction SHALL increment the hold count; when it reaches ACCEL_TICKS it SHALL clear, and step SHALL increment, saturating at STEP_MAX.
REQ-024 Moves SHALL use the step value at the tick: MOVE_L sets x = max(x-step, X_MIN); MOVE_R sets x = min(x+step, X_MAX).
REQ-024a Position arithmetic SHALL be X_W+1 bits wide so it never wraps.
REQ-024b At a wall, x SHALL hold while the state remains MOVE_x and acceleration continues.
REQ-025 recenter SHALL take priority over a tick: on the next clk edge, x = X_CTR, state = IDLE and step = STEP_MIN; the tick counter SHALL be unaffected.
REQ-026 at_left, at_right and moving SHALL be decoded combinationally from the registered x and state.

Reset
REQ-027 While resetn = 0, the block SHALL asynchronously force x = X_CTR, state = IDLE, step = STEP_MIN, hold count = 0 and tick counter = 0.
REQ-027a Consequently, during reset tick = 0 and moving = 0.
REQ-028 Reset asserted mid-move SHALL abort the move immediately; the first tick after release SHALL occur TICK_DIV cycles after release.

Structure
REQ-029 SCREEN_W, HALF_W defaults and the state encoding SHALL live in a shared package, breakout_pkg, for reuse by the ball and collision blocks.
REQ-030 The tick counter SHALL be a sub-module, paddle_tick_gen (parameter TICK_DIV; ports clk, resetn, tick).

Verification (TICK_DIV = 4, other parameters at default)
REQ-031 Reset release -> x = 160, step = 1, moving = 0, first tick 4 cycles later.
REQ-032 Hold btn_right for 20 ticks -> x = 160 +8·1 +8·2 +4·3 = 196; step = 3 after tick 16.
REQ-033 Hold btn_left from x = 42 with step = 4 -> x = 40, at_left = 1; x stays at 40 on further ticks.
REQ-034 Both buttons high for 3 ticks -> state IDLE, x unchanged, step = 1.
REQ-035 recenter asserted on a tick cycle while in MOVE_R at x = 250 -> next cycle x = 160, moving = 0.
REQ-036 resetn pulsed low mid-move at x = 200 -> x = 160 asynchronously, before the next clk edge.
